clock_divider_prog: RTL and testbench
=====================================

Name: clock_divider_prog

Overview:
- Runtime-programmable successor to the fixed clock divider.
- Divides clock_in by a ratio loaded through a valid/ready config port and produces:
  - a registered divided clock (clock_out)
  - a one-cycle period-start pulse (tick)
- Ratio changes take effect only at period boundaries, so clock_out never glitches or produces a truncated period.
- Sits between the board clock and slow consumers (display scan, debouncers, LED blink) as a clock/enable source.

Parameters:
- CNT_W, 16: width of the counter and ratio registers.
- DEFAULT_DIV, 4: ratio loaded at reset. Must be >= 2.
- DEFAULT_DUTY, 2: high-cycle count loaded at reset. Used only when CLKDIV_DUTY_EN is defined.

Ports:
- clock_in, in, 1: system clock. All logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- en, in, 1: run enable. Low forces the idle state.
- cfg_valid, in, 1: new configuration offered.
- cfg_ready, out, 1: configuration can be accepted. Equals !pending.
- cfg_div, in, CNT_W: requested divide ratio.
- cfg_duty, in, CNT_W: requested high count. Present only with CLKDIV_DUTY_EN.
- clock_out, out, 1: divided clock, registered.
- tick, out, 1: one-cycle pulse, registered, high on the first cycle of each period.

Behaviour:
- Reset (asynchronous, active-high) values:
  - count=0, running=0, pending=0
  - div_active=DEFAULT_DIV, div_shadow=DEFAULT_DIV
  - clock_out=0, tick=0, cfg_ready=1
- Ratio clamp: a cfg_div value below 2 is stored as 2. Ratio is in clock_in cycles, maximum 2^CNT_W-1.
- High count: hi = div_active>>1. Examples: div 4 gives 2 high / 2 low; div 5 gives 2 high / 3 low.
- States: IDLE (running=0) and RUN (running=1).
- IDLE, en=0:
  - count=0, clock_out=0, tick=0.
  - An accepted config writes div_active directly.
  - A pending shadow value is copied into div_active and pending clears.
- IDLE to RUN: on the first edge with en=1:
  - running<=1, count<=0, clock_out<=1, tick<=1.
- RUN, en=1, each edge:
  - If count==div_active-1: count<=0. If pending, div_active<=div_shadow and pending<=0.
  - Otherwise count<=count+1.
  - Then clock_out <= (new count < hi, using the new div_active).
  - tick <= (new count == 0).
- RUN to IDLE: on an edge with en=0, go to IDLE at once.
  - clock_out and tick are 0 after that edge.
  - Any partial period is abandoned.
- Config handshake:
  - Transfer occurs on an edge where cfg_valid && cfg_ready.
  - In RUN: the value goes to div_shadow and pending<=1, so cfg_ready drops the next cycle.
  - cfg_valid with cfg_ready=0 is ignored. The requester must hold the value.
- Simultaneous accept and period wrap: the new value goes to the shadow and applies at the following wrap, not the current one.
- Period length is exactly div_active edges.
- Latency:
  - From en rising to the first tick: 1 edge.
  - From accept to the new ratio: at most the remainder of the current period plus one full period.
- Reset asserted mid-period: everything returns to reset values asynchronously. The first period after reset release is a full period.

Optional Feature:
- Macro: CLKDIV_DUTY_EN.
- Defined:
  - Adds the cfg_duty port, plus shadow and active duty registers loaded through the same handshake.
  - hi = duty_active, clamped to the range [1, div_active-1] at load time.
- Undefined:
  - No cfg_duty port, no duty registers.
  - hi = div_active>>1, giving near-50% duty.

Decomposition:
- Shared package clkdiv_pkg holds:
  - CNT_W default
  - minimum ratio constant MIN_DIV=2
  - the clamp function for div and duty
- One natural sub-module is clkdiv_cfg_shadow: the valid/ready capture, shadow registers, pending flag and clamp logic.
- The top level keeps the counter, the IDLE/RUN control and the output registers.

Test Plan:
- Reset, then en=1 with the default div 4: clock_out = 1,1,0,0 repeating; tick high on cycles 0,4,8.
- In RUN, load div 5 mid-period:
  - cfg_ready drops the cycle after accept.
  - The current 4-cycle period completes.
  - Next periods are 1,1,0,0,0; tick spacing is 5.
  - cfg_ready returns to 1 after the wrap.
- Load cfg_div=0 and cfg_div=1: both behave as div 2, i.e. clock_out alternates 1,0 and tick fires every cycle pair.
- Drop en mid-period: clock_out=0 and tick=0 next cycle. Re-assert en: tick on the first edge and a full period follows.
- Assert reset mid-period with a config pending: outputs clear immediately; after release, div returns to DEFAULT_DIV and the pending value is discarded.
- With CLKDIV_DUTY_EN, div 8 and duty 3: clock_out = 1,1,1,0,0,0,0,0. With duty 9: clamped to 7.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants, state type and ratio/duty clamp helpers for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned MIN_DIV       = 2;

  typedef enum logic [0:0] {StIdle, StRun} clkdiv_state_e;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Duty is bounded so both the high and the low phase last at least one cycle.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] div);
    if (duty < 32'd1) return 32'd1;
    if (duty > div - 32'd1) return div - 32'd1;
    return duty;
  endfunction

endpackage

// File: rtl/clkdiv_cfg_shadow.sv
// Config handshake, shadow/active ratio registers and pending flag.
// With CLKDIV_DUTY_EN defined, also carries shadow/active duty registers.
module clkdiv_cfg_shadow
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 4
`ifdef CLKDIV_DUTY_EN
  , parameter int unsigned DEFAULT_DUTY = 2
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             running_i,
  input  logic             wrap_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_div_i,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] cfg_duty_i,
`endif
  output logic             cfg_ready_o,
  output logic [CNT_W-1:0] div_active_o,
  output logic [CNT_W-1:0] hi_next_o
);

  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] div_in;
  logic             accept;

`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] duty_active_q, duty_active_d;
  logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [CNT_W-1:0] duty_in;
`endif

  always_comb begin
    accept       = cfg_valid_i && !pending_q;
    div_in       = CNT_W'(clamp_div(32'(cfg_div_i)));
    div_active_d = div_active_q;
    div_shadow_d = div_shadow_q;
    pending_d    = pending_q;
`ifdef CLKDIV_DUTY_EN
    duty_in       = CNT_W'(clamp_duty(32'(cfg_duty_i), 32'(div_in)));
    duty_active_d = duty_active_q;
    duty_shadow_d = duty_shadow_q;
`endif
    if (!running_i) begin
      // While idle there is no period to protect, so values land in the active set directly.
      if (accept) begin
        div_active_d = div_in;
`ifdef CLKDIV_DUTY_EN
        duty_active_d = duty_in;
`endif
      end else if (pending_q) begin
        div_active_d = div_shadow_q;
        pending_d    = 1'b0;
`ifdef CLKDIV_DUTY_EN
        duty_active_d = duty_shadow_q;
`endif
      end
    end else begin
      if (wrap_i && pending_q) begin
        div_active_d = div_shadow_q;
        pending_d    = 1'b0;
`ifdef CLKDIV_DUTY_EN
        duty_active_d = duty_shadow_q;
`endif
      end
      // accept implies !pending_q, so this never collides with the wrap update above.
      if (accept) begin
        div_shadow_d = div_in;
        pending_d    = 1'b1;
`ifdef CLKDIV_DUTY_EN
        duty_shadow_d = duty_in;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_active_q <= CNT_W'(DEFAULT_DIV);
      div_shadow_q <= CNT_W'(DEFAULT_DIV);
      pending_q    <= 1'b0;
    end else begin
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      pending_q    <= pending_d;
    end
  end

`ifdef CLKDIV_DUTY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_active_q <= CNT_W'(DEFAULT_DUTY);
      duty_shadow_q <= CNT_W'(DEFAULT_DUTY);
    end else begin
      duty_active_q <= duty_active_d;
      duty_shadow_q <= duty_shadow_d;
    end
  end

  assign hi_next_o = duty_active_d;
`else
  assign hi_next_o = div_active_d >> 1;
`endif

  assign cfg_ready_o  = !pending_q;
  assign div_active_o = div_active_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: registered divided clock plus period-start tick.
// Optional programmable duty cycle when CLKDIV_DUTY_EN is defined.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 4
`ifdef CLKDIV_DUTY_EN
  , parameter int unsigned DEFAULT_DUTY = 2
`endif
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] cfg_duty,
`endif
  output logic             clock_out,
  output logic             tick
);

  clkdiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] hi_next;
  logic             running;
  logic             wrap;

  assign running = (state_q == StRun);
  assign wrap    = running && en && (count_q == div_active - CNT_W'(1));

  clkdiv_cfg_shadow #(
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (DEFAULT_DIV)
`ifdef CLKDIV_DUTY_EN
    , .DEFAULT_DUTY (DEFAULT_DUTY)
`endif
  ) u_cfg_shadow (
    .clk_i        (clock_in),
    .rst_i        (reset),
    .running_i    (running),
    .wrap_i       (wrap),
    .cfg_valid_i  (cfg_valid),
    .cfg_div_i    (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_duty_i   (cfg_duty),
`endif
    .cfg_ready_o  (cfg_ready),
    .div_active_o (div_active),
    .hi_next_o    (hi_next)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    clock_out_d = 1'b0;
    tick_d      = 1'b0;
    case (state_q)
      StIdle: begin
        count_d = '0;
        if (en) begin
          state_d     = StRun;
          clock_out_d = 1'b1;
          tick_d      = 1'b1;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          count_d     = wrap ? '0 : count_q + CNT_W'(1);
          // hi_next already reflects a ratio swapped in on this edge.
          clock_out_d = (count_d < hi_next);
          tick_d      = (count_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
    end
  end

  assign clock_out = clock_out_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed steps plus random traffic
// against a phase/ratio reference model. Duty checks are built when CLKDIV_DUTY_EN is defined.
module tb_clock_divider_prog;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_duty;
  logic        clock_out;
  logic        tick;

  int total = 0;
  int bad   = 0;

`ifdef CLKDIV_DUTY_EN
  localparam bit DutyEn = 1'b1;
`else
  localparam bit DutyEn = 1'b0;
`endif

  clock_divider_prog #(
    .CNT_W       (16),
    .DEFAULT_DIV (4)
`ifdef CLKDIV_DUTY_EN
    , .DEFAULT_DUTY (2)
`endif
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_duty  (cfg_duty),
`endif
    .clock_out (clock_out),
    .tick      (tick)
  );

  always #5 clock_in = ~clock_in;

  // Reference model: position within the current period and the ratio in force.
  bit m_run;
  bit m_pending;
  bit m_acc;
  int m_phase;
  int m_div;
  int m_shadow;
  int m_duty;
  int m_duty_sh;

  function automatic int ref_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int ref_duty(input int y, input int d);
    if (y < 1) return 1;
    if (y > d - 1) return d - 1;
    return y;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pending = 0; m_phase = 0;
    m_div = 4; m_shadow = 4; m_duty = 2; m_duty_sh = 2;
  endfunction

  function automatic void model_edge();
    int nd;
    int ny;
    m_acc = cfg_valid && !m_pending;
    nd    = ref_div(int'(cfg_div));
    ny    = ref_duty(int'(cfg_duty), nd);
    if (!m_run) begin
      if (m_acc) begin
        m_div = nd; m_duty = ny;
      end else if (m_pending) begin
        m_div = m_shadow; m_duty = m_duty_sh; m_pending = 0;
      end
      if (en) begin
        m_run = 1; m_phase = 0;
      end
    end else begin
      if (en) begin
        m_phase++;
        if (m_phase == m_div) begin
          m_phase = 0;
          if (m_pending) begin
            m_div = m_shadow; m_duty = m_duty_sh; m_pending = 0;
          end
        end
      end else begin
        m_run = 0;
      end
      if (m_acc) begin
        m_shadow = nd; m_duty_sh = ny; m_pending = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int hi;
    @(posedge clock_in);
    model_edge();
    #1;
    hi = DutyEn ? m_duty : m_div / 2;
    chk("model_clock_out", int'(clock_out), int'(m_run && (m_phase < hi)));
    chk("model_tick", int'(tick), int'(m_run && (m_phase == 0)));
    chk("model_cfg_ready", int'(cfg_ready), int'(!m_pending));
  endtask

  // Holds an offer until the model sees it accepted, bounded by a cycle budget.
  task automatic offer(input int d, input int y);
    bit got = 0;
    cfg_valid = 1'b1;
    cfg_div   = 16'(d);
    cfg_duty  = 16'(y);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = m_acc;
    end
    cfg_valid = 1'b0;
    chk("offer_accepted", int'(got), 1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_duty = '0;
    model_reset();
    #3;
    chk("rst_clock_out", int'(clock_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clock_in); #1;
    reset = 1'b0;
    step();
    step();

    // Default ratio 4: 1,1,0,0 with tick every fourth cycle.
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("dflt_clock_out", int'(clock_out), int'((k % 4) < 2));
      chk("dflt_tick", int'(tick), int'((k % 4) == 0));
    end

    // Offer lands on the wrap edge, so the current 4-cycle period is followed by one more.
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_duty = 16'd2;
    step();
    cfg_valid = 1'b0;
    chk("div5_ready_drop", int'(cfg_ready), 0);
    for (int k = 0; k < 3; k++) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("div5_clock_out", int'(clock_out), int'((k % 5) < 2));
      chk("div5_tick", int'(tick), int'((k % 5) == 0));
      if (k == 0) chk("div5_ready_back", int'(cfg_ready), 1);
    end

    // Ratios 0 and 1 clamp to 2.
    offer(0, 1);
    for (int k = 0; k < 10; k++) step();
    offer(1, 1);
    for (int k = 0; k < 10; k++) step();

    // Drop en mid-period and re-assert.
    offer(6, 3);
    for (int k = 0; k < 14; k++) step();
    en = 1'b0;
    step();
    chk("en_drop_clock_out", int'(clock_out), 0);
    chk("en_drop_tick", int'(tick), 0);
    step();
    en = 1'b1;
    step();
    chk("en_rise_tick", int'(tick), 1);
    chk("en_rise_clock_out", int'(clock_out), 1);
    for (int k = 0; k < 12; k++) step();

    // Reset with a config pending: pending value must be discarded.
    offer(7, 3);
    step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_clock_out", int'(clock_out), 0);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clock_in); #1;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("post_rst_clock_out", int'(clock_out), int'((k % 4) < 2));
      chk("post_rst_tick", int'(tick), int'((k % 4) == 0));
    end

`ifdef CLKDIV_DUTY_EN
    en = 1'b0;
    step();
    offer(8, 3);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("duty3_clock_out", int'(clock_out), int'((k % 8) < 3));
    end
    en = 1'b0;
    step();
    offer(8, 9);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("duty9_clock_out", int'(clock_out), int'((k % 8) < 7));
    end
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en        = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = 16'($urandom_range(0, 12));
      cfg_duty  = 16'($urandom_range(0, 13));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
